// File: rtl/halfadder.sv
// Registered lane-parallel half adder with combinational taps, a one-cycle
// valid qualifier and a saturating count of valid samples that carried.
module halfadder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] s_comb,
   output logic [WIDTH-1:0] c_comb,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_count
);

   logic carry_event;

   assign s_comb      = a ^ b;
   assign c_comb      = a & b;
   assign carry_event = in_valid & (|c_comb);

   // s/c keep the last valid result while out_valid drops for idle cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s         <= '0;
         c         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s <= s_comb;
            c <= c_comb;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_count <= '0;
      end else if (carry_event && (carry_count != '1)) begin
         carry_count <= carry_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_halfadder.sv
// Directed-vector bench for halfadder: a 1-lane, a 4-lane and a 2-bit-counter
// instance share clock and reset; expected values are hand-computed.
module tb_halfadder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       a1, b1, v1;
   logic       sc1, cc1, s1, c1, ov1;
   logic [7:0] cnt1;

   logic [3:0] a4, b4;
   logic       v4;
   logic [3:0] sc4, cc4, s4, c4;
   logic       ov4;
   logic [7:0] cnt4;

   logic       a2, b2, v2;
   logic       sc2, cc2, s2, c2, ov2;
   logic [1:0] cnt2;

   int n_cmp = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   halfadder #(.WIDTH(1), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
      .s_comb(sc1), .c_comb(cc1), .s(s1), .c(c1),
      .out_valid(ov1), .carry_count(cnt1)
   );

   halfadder #(.WIDTH(4), .CNT_W(8)) u4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
      .s_comb(sc4), .c_comb(cc4), .s(s4), .c(c4),
      .out_valid(ov4), .carry_count(cnt4)
   );

   halfadder #(.WIDTH(1), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .a(a2), .b(b2), .in_valid(v2),
      .s_comb(sc2), .c_comb(cc2), .s(s2), .c(c2),
      .out_valid(ov2), .carry_count(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive u1 at the falling edge, check comb taps, then registered outputs after the rising edge
   task automatic vec1(input logic a, input logic b, input logic v,
                       input logic es, input logic ec, input logic eov, input logic [7:0] ecnt);
      @(negedge clk);
      a1 = a; b1 = b; v1 = v;
      #1;
      check("s_comb1", 32'(sc1), 32'(a ^ b));
      check("c_comb1", 32'(cc1), 32'(a & b));
      @(posedge clk); #1;
      check("s1", 32'(s1), 32'(es));
      check("c1", 32'(c1), 32'(ec));
      check("out_valid1", 32'(ov1), 32'(eov));
      check("count1", 32'(cnt1), 32'(ecnt));
   endtask

   initial begin
      a1 = 0; b1 = 0; v1 = 0;
      a4 = '0; b4 = '0; v4 = 0;
      a2 = 0; b2 = 0; v2 = 0;

      // reset state, held while rst=1 across edges
      #3;
      check("rst_s", 32'(s1), 0);
      check("rst_ov", 32'(ov1), 0);
      @(posedge clk); #1;
      check("rst_cnt", 32'(cnt1), 0);
      check("rst_c4", 32'(c4), 0);
      @(negedge clk);
      rst = 0;

      // truth table, expected registered value and running carry count
      vec1(0, 0, 1, 0, 0, 1, 0);
      vec1(0, 1, 1, 1, 0, 1, 0);
      vec1(1, 0, 1, 1, 0, 1, 0);
      vec1(1, 1, 1, 0, 1, 1, 1);

      // valid gating: 01 valid then 11 invalid leaves s/c=1/0 and count unchanged
      vec1(0, 1, 1, 1, 0, 1, 1);
      vec1(1, 1, 0, 1, 0, 0, 1);

      // back-to-back 01/11
      vec1(0, 1, 1, 1, 0, 1, 1);
      vec1(1, 1, 1, 0, 1, 1, 2);
      vec1(0, 1, 1, 1, 0, 1, 2);
      vec1(1, 1, 1, 0, 1, 1, 3);

      // one idle cycle so registers are non-zero but out_valid low, then async reset mid-cycle
      vec1(0, 0, 0, 0, 1, 0, 3);
      #5;
      rst = 1;
      #1;
      check("async_s", 32'(s1), 0);
      check("async_c", 32'(c1), 0);
      check("async_ov", 32'(ov1), 0);
      check("async_cnt", 32'(cnt1), 0);
      a1 = 1; b1 = 1;
      #1;
      check("async_c_comb", 32'(cc1), 1);
      @(negedge clk);
      rst = 0;
      a1 = 0; b1 = 0;

      // multi-lane
      @(negedge clk);
      a4 = 4'b1100; b4 = 4'b1010; v4 = 1;
      #1;
      check("s_comb4", 32'(sc4), 32'h6);
      check("c_comb4", 32'(cc4), 32'h8);
      @(posedge clk); #1;
      check("s4", 32'(s4), 32'h6);
      check("c4", 32'(c4), 32'h8);
      check("out_valid4", 32'(ov4), 1);
      check("count4", 32'(cnt4), 1);
      @(negedge clk);
      a4 = 4'b0011; b4 = 4'b0100;
      @(posedge clk); #1;
      check("s4_nocarry", 32'(s4), 32'h7);
      check("c4_nocarry", 32'(c4), 32'h0);
      check("count4_hold", 32'(cnt4), 1);
      @(negedge clk);
      v4 = 0;

      // saturation of a 2-bit counter
      for (int i = 0; i < 5; i++) begin
         logic [1:0] exp_cnt;
         exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
         @(negedge clk);
         a2 = 1; b2 = 1; v2 = 1;
         @(posedge clk); #1;
         check("count2_sat", 32'(cnt2), 32'(exp_cnt));
      end
      check("c2_sat", 32'(c2), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
